sipo_frame_ctrl: RTL and testbench
==================================

# sipo_frame_ctrl

Controller that sequences a serial-in/parallel-out shift register. It frames a qualified serial bit stream into WIDTH-bit words using a start-of-frame marker, and hands each completed word to downstream logic over a valid/ready handshake. A separate output holding register lets the next word shift in while the previous word waits for acceptance. It sits between a serial receiver front end and any word-wide consumer.

## Interface
Parameters:
- WIDTH, 8: word length in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = first received bit lands in pout[WIDTH-1]; 0 = first bit lands in pout[0].

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- sin  in  1  serial data bit; used only when sin_valid=1.
- sin_valid  in  1  qualifies sin for this cycle.
- sof  in  1  start of frame; meaningful only when sin_valid=1. Marks the current bit as bit 0 of a new word.
- pout  out  WIDTH  completed parallel word.
- pout_valid  out  1  pout holds an unaccepted word.
- pout_ready  in  1  downstream accepts pout when pout_valid=1.
- bit_cnt  out  $clog2(WIDTH+1)  number of bits in the current partial word.
- busy  out  1  the state is SHIFT.
- abort  out  1  one-cycle pulse: a partial word was discarded by sof.
- overrun  out  1  sticky flag: a completed word was dropped.
- clr_ovr  in  1  clears overrun.

## Operation
- States:
  - IDLE: the state after reset. Bits with sin_valid=1 and sof=0 are ignored. sin_valid=1 with sof=1 shifts the bit in, sets bit_cnt=1 and moves to SHIFT.
  - SHIFT: each cycle with sin_valid=1 shifts sin in and increments bit_cnt. The state never returns to IDLE except by reset; framing is continuous.
- Shift direction:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
- Word completion: a shift with bit_cnt=WIDTH-1 completes the word. The completed word, including the current bit, is offered to the output register, and bit_cnt returns to 0 in SHIFT.
- sof in SHIFT with bit_cnt>0:
  - The partial word is discarded.
  - The current bit becomes bit 0 of a new word and bit_cnt=1.
  - abort pulses for one cycle.
- sof in SHIFT with bit_cnt=0 is a normal word start; abort stays 0.
- Output register:
  - A completed word is loaded into pout with pout_valid=1 if pout_valid=0, or if pout_valid=1 and pout_ready=1 in the same cycle.
  - If a word completes while pout_valid=1 and pout_ready=0: the new word is dropped, pout is unchanged and overrun is set.
  - pout_ready=1 with no completing word clears pout_valid.
- overrun: clr_ovr=1 clears it. If a set and a clear occur in the same cycle, the set wins.
- Reset: rst_n=0 forces state=IDLE, bit_cnt=0, pout=0, pout_valid=0, busy=0, abort=0, overrun=0. Reset mid-word discards the partial word and any pending output word. Shift register contents need no reset.

## Timing
- Latency: if the last bit is sampled at edge N, pout and pout_valid are updated at edge N, so they are visible in cycle N+1.
- Maximum throughput is one word per WIDTH valid bits, back to back, with no dead cycle between words.
- pout is stable while pout_valid=1 and pout_ready=0. A transfer occurs on any edge where pout_valid and pout_ready are both 1.
- abort is high in the cycle after the discarding sof edge only.
- bit_cnt and busy are registered and reflect the bits shifted up to the previous edge.
- sof with sin_valid=0 has no effect. sin_valid=0 holds all state.

## Structure
- Shared package sipo_pkg contains:
  - enum state_t {IDLE, SHIFT};
  - function cnt_w(width) returning $clog2(width+1), used for the bit_cnt width.
- One sub-module, sipo_shreg. Parameters WIDTH and MSB_FIRST; ports clk, en, sin, q[WIDTH-1:0]. It is a plain enable-gated shift chain with no reset.
- The FSM, bit counter, output register, handshake and flags live in sipo_frame_ctrl.

## Test plan
- Reset, then MSB_FIRST=1 and WIDTH=8: sof on the first bit, stream 1,0,1,1,0,0,1,0 on consecutive cycles with pout_ready=1 → pout=8'hB2 and pout_valid=1 one cycle after the 8th bit. busy=1 from the bit after sof; abort=0 and overrun=0 throughout.
- MSB_FIRST=0: the same stream → pout=8'h4D.
- Back-to-back words 8'hA5 then 8'h3C with pout_ready held 0 → 8'hA5 is held and overrun=1 after the 16th bit. Pulse clr_ovr → overrun=0 next cycle; raise pout_ready → pout_valid=0.
- Send sof after 5 bits, then 8 more bits of 8'hFF → abort pulses one cycle, bit_cnt returns to 1 and the next pout is 8'hFF.
- In IDLE, drive 20 bits with sof=0 → bit_cnt stays 0 and pout_valid stays 0. Assert rst_n=0 while bit_cnt=4 and pout_valid=1 → all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out framing controller.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter able to hold every value from 0 to width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Enable-gated shift chain with no reset; direction chosen by MSB_FIRST.
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next chain contents: shift toward the MSB or toward the LSB when enabled.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (MSB_FIRST) q_d = {q_q[WIDTH-2:0], sin};
      else           q_d = {sin, q_q[WIDTH-1:1]};
    end
  end

  // Contents are don't-care until a full word has been shifted in.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a qualified serial stream into WIDTH-bit words using a start-of-frame
// marker and hands each word downstream through a one-deep holding register.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sof,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt,
  output logic                     busy,
  output logic                     abort,
  output logic                     overrun,
  input  logic                     clr_ovr
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;

  logic             shift_en;
  logic             word_done;
  logic             ovr_set;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word_next;

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk (clk),
    .en  (shift_en),
    .sin (sin),
    .q   (sreg)
  );

  // The completed word must include the bit being shifted in this cycle.
  assign word_next = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};

  // Framing: start on sof, count bits, complete at WIDTH, restart on a mid-word sof.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    abort_d   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    if (sin_valid) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            shift_en  = 1'b1;
            bit_cnt_d = ONE;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (sof) begin
            bit_cnt_d = ONE;
            abort_d   = (bit_cnt_q != '0);
          end else if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: load if empty or draining this cycle, otherwise drop and flag.
  always_comb begin
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    ovr_set      = 1'b0;
    if (word_done) begin
      if (!pout_valid_q || pout_ready) begin
        pout_d       = word_next;
        pout_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (pout_ready) begin
      pout_valid_d = 1'b0;
    end
    if (ovr_set)      overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      abort_q      <= abort_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign bit_cnt    = bit_cnt_q;
  assign busy       = (state_q == SHIFT);
  assign abort      = abort_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_frame_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0, sin = 1'b0, sin_valid = 1'b0, sof = 1'b0;
  logic pout_ready = 1'b0, clr_ovr = 1'b0;

  logic [W-1:0]  pout_m, pout_l;
  logic          pv_m, pv_l, busy_m, busy_l, ab_m, ab_l, ov_m, ov_l;
  logic [CW-1:0] bc_m, bc_l;

  int checks = 0;
  int errors = 0;

  // Reference model: frame held as a list of received bits.
  bit           inFrame;
  bit           frameBits[$];
  bit           mValid, mOvr, mAbort;
  logic [W-1:0] expMsb[$];
  logic [W-1:0] expLsb[$];

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready), .bit_cnt(bc_m),
    .busy(busy_m), .abort(ab_m), .overrun(ov_m), .clr_ovr(clr_ovr)
  );

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready), .bit_cnt(bc_l),
    .busy(busy_l), .abort(ab_l), .overrun(ov_l), .clr_ovr(clr_ovr)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the model over one clock edge with the given inputs.
  task automatic modelStep(input bit r, input bit sv, input bit s, input bit sf,
                           input bit rdy, input bit clr);
    bit newAbort = 1'b0;
    bit done = 1'b0;
    bit setOvr = 1'b0;
    logic [W-1:0] wm = '0;
    logic [W-1:0] wl = '0;
    if (!r) begin
      inFrame = 1'b0;
      frameBits.delete();
      mValid = 1'b0;
      mOvr = 1'b0;
      mAbort = 1'b0;
      expMsb.delete();
      expLsb.delete();
      return;
    end
    if (sv) begin
      if (sf) begin
        if (inFrame && frameBits.size() > 0) newAbort = 1'b1;
        frameBits.delete();
        frameBits.push_back(s);
        inFrame = 1'b1;
      end else if (inFrame) begin
        frameBits.push_back(s);
      end
      if (frameBits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = frameBits[i];
          wl[i] = frameBits[i];
        end
        frameBits.delete();
      end
    end
    if (done) begin
      if (!mValid || rdy) begin
        mValid = 1'b1;
        expMsb.push_back(wm);
        expLsb.push_back(wl);
      end else begin
        setOvr = 1'b1;
      end
    end else if (rdy) begin
      mValid = 1'b0;
    end
    if (setOvr)   mOvr = 1'b1;
    else if (clr) mOvr = 1'b0;
    mAbort = newAbort;
  endtask

  task automatic checkOutput();
    check("bit_cnt_msb", bc_m, frameBits.size());
    check("bit_cnt_lsb", bc_l, frameBits.size());
    check("busy_msb", busy_m, inFrame);
    check("busy_lsb", busy_l, inFrame);
    check("abort_msb", ab_m, mAbort);
    check("abort_lsb", ab_l, mAbort);
    check("overrun_msb", ov_m, mOvr);
    check("overrun_lsb", ov_l, mOvr);
    check("pout_valid_msb", pv_m, mValid);
    check("pout_valid_lsb", pv_l, mValid);
  endtask

  task automatic applyStimulus(input bit r, input bit sv, input bit s, input bit sf,
                               input bit rdy, input bit clr);
    rst_n = r;
    sin_valid = sv;
    sin = s;
    sof = sf;
    pout_ready = rdy;
    clr_ovr = clr;
    modelStep(r, sv, s, sf, rdy, clr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [W-1:0] word, input bit firstSof, input bit rdy);
    for (int i = 0; i < W; i++)
      applyStimulus(1'b1, 1'b1, word[W-1-i], firstSof && (i == 0), rdy, 1'b0);
  endtask

  // Monitor: a transfer happens at the next edge whenever valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pv_m && pout_ready) begin
        if (expMsb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=%0h expected=none", pout_m);
        end else begin
          check("pout_msb", pout_m, expMsb.pop_front());
          check("pout_lsb", pout_l, expLsb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_pout", pout_m, 0);

    // First word, B2 MSB-first / 4D LSB-first.
    sendWord(8'hB2, 1'b1, 1'b1);
    check("word1_msb", pout_m, 8'hB2);
    check("word1_lsb", pout_l, 8'h4D);

    // Drain, then two words with no acceptance.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendWord(8'hA5, 1'b0, 1'b0);
    sendWord(8'h3C, 1'b0, 1'b0);
    check("held_word", pout_m, 8'hA5);
    check("overrun_set", ov_m, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-word sof discards a partial word.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 1'(i & 1), 1'b0, 1'b1, 1'b0);
    sendWord(8'hFF, 1'b1, 1'b1);
    check("after_abort_word", pout_m, 8'hFF);

    // Randomized traffic with gaps, stray sof, backpressure and rare resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                    1'($urandom), $urandom_range(0, 15) == 0,
                    1'($urandom), $urandom_range(0, 7) == 0);
    end

    // Idle bits are ignored, then reset with a partial and a pending word.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    check("idle_bit_cnt", bc_m, 0);
    w = 8'h5A;
    sendWord(w, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    check("partial_cnt", bc_m, 4);
    check("pending_valid", pv_m, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_pout_msb", pout_m, 0);
    check("reset_pout_lsb", pout_l, 0);
    check("scoreboard_left", expMsb.size(), mValid ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
